// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the decode-stage interlock signals exchanged between the
//   pipeline (master) and the hazard/scoreboard block (slave).
//   master : drives decode instruction info, execute allow-in, load
//            completion and flush; receives ds_stall, div_busy, pending.
//   slave  : the reverse direction, used by hazard_ctrl.
interface hazard_ctrl_if;
   logic        ds_valid;
   logic [4:0]  ds_rf_raddr1;
   logic [4:0]  ds_rf_raddr2;
   logic        ds_src1_used;
   logic        ds_src2_used;
   logic [4:0]  ds_dest;
   logic        ds_reg_we;
   logic        ds_is_load;
   logic        ds_is_div;
   logic        es_allowin;
   logic        ms_load_done;
   logic [4:0]  ms_load_dest;
   logic        flush;
   logic        ds_stall;
   logic        div_busy;
   logic [31:0] pending;

   modport master (
      output ds_valid, ds_rf_raddr1, ds_rf_raddr2, ds_src1_used, ds_src2_used,
             ds_dest, ds_reg_we, ds_is_load, ds_is_div, es_allowin,
             ms_load_done, ms_load_dest, flush,
      input  ds_stall, div_busy, pending
   );

   modport slave (
      input  ds_valid, ds_rf_raddr1, ds_rf_raddr2, ds_src1_used, ds_src2_used,
             ds_dest, ds_reg_we, ds_is_load, ds_is_div, es_allowin,
             ms_load_done, ms_load_dest, flush,
      output ds_stall, div_busy, pending
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Decode-stage interlock and scoreboard for results that forwarding
//   cannot yet supply: outstanding loads and the multi-cycle divider.
//   Holds decode (ds_stall) until those results become forwardable.
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   hz     : hazard_ctrl_if.slave -- decode info in; ds_stall, div_busy,
//            pending (32-bit scoreboard, bit r = r awaiting write) out
// Parameter:
//   DIV_LAT : divider latency, issue to forwardable result (2..15)
module hazard_ctrl #(
   parameter int DIV_LAT = 8
) (
   input  logic         clk,
   input  logic         resetn,
   hazard_ctrl_if.slave hz
);

   logic [31:0] pend_q;
   logic [31:0] pend_d;
   logic [31:0] clr_mask;
   logic [31:0] set_mask;
   logic [31:0] eff;
   logic [3:0]  div_cnt;
   logic [3:0]  div_cnt_d;
   logic [4:0]  div_dest;
   logic [4:0]  div_dest_d;
   logic        div_done;
   logic        div_busy_w;
   logic        raw;
   logic        waw;
   logic        struc;
   logic        stall;
   logic        issue;
   logic        trk;

   assign div_busy_w = (div_cnt != 4'd0);
   assign div_done   = (div_cnt == 4'd1);

   // Results completing this cycle are forwardable next cycle, so their
   // bits are already ignored for the hazard check.
   always_comb begin
      clr_mask = '0;
      if (hz.ms_load_done) clr_mask[hz.ms_load_dest] = 1'b1;
      if (div_done)        clr_mask[div_dest]        = 1'b1;
   end

   assign eff = pend_q & ~clr_mask;

   assign raw   = (hz.ds_src1_used & eff[hz.ds_rf_raddr1]) |
                  (hz.ds_src2_used & eff[hz.ds_rf_raddr2]);
   assign waw   = hz.ds_reg_we & eff[hz.ds_dest];
   assign struc = hz.ds_is_div & div_busy_w & ~div_done;
   assign stall = hz.ds_valid & ~hz.flush & (raw | waw | struc);

   assign issue = hz.ds_valid & hz.es_allowin & ~stall & ~hz.flush;
   assign trk   = hz.ds_reg_we & (hz.ds_dest != 5'd0) &
                  (hz.ds_is_load | hz.ds_is_div);

   always_comb begin
      set_mask = '0;
      if (issue & trk) set_mask[hz.ds_dest] = 1'b1;
   end

   // Set is applied after clear so a simultaneous set on the same
   // register wins; bit 0 is forced low.
   always_comb begin
      if (hz.flush) pend_d = '0;
      else          pend_d = (eff | set_mask) & ~32'h0000_0001;
   end

   // A new div may reload the counter in the same cycle the previous one
   // completes; the old destination bit is cleared through clr_mask.
   always_comb begin
      div_cnt_d  = div_cnt;
      div_dest_d = div_dest;
      if (hz.flush) begin
         div_cnt_d  = 4'd0;
         div_dest_d = 5'd0;
      end else if (issue & hz.ds_is_div) begin
         div_cnt_d  = 4'(DIV_LAT);
         div_dest_d = (hz.ds_reg_we && hz.ds_dest != 5'd0) ? hz.ds_dest : 5'd0;
      end else if (div_busy_w) begin
         div_cnt_d  = div_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_q   <= '0;
         div_cnt  <= 4'd0;
         div_dest <= 5'd0;
      end else begin
         pend_q   <= pend_d;
         div_cnt  <= div_cnt_d;
         div_dest <= div_dest_d;
      end
   end

   assign hz.ds_stall = stall;
   assign hz.div_busy = div_busy_w;
   assign hz.pending  = pend_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Decode-stage interlock and scoreboard; the stalling counterpart of the forwarding path. Forwarding covers single-cycle results. This block tracks register writes whose data is not yet forwardable: loads waiting for memory, and the multi-cycle divider. It holds the decode stage until those results exist. It sits beside the decode stage and feeds `ds_stall` into the decode allow-in logic.

## Interface
- `DIV_LAT`, default 8: divider latency in cycles, from issue to result forwardable; legal range 2..15.
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `ds_valid` in 1: decode holds a valid instruction.
- `ds_rf_raddr1` in 5: source 1 register.
- `ds_rf_raddr2` in 5: source 2 register.
- `ds_src1_used` in 1: source 1 is actually read.
- `ds_src2_used` in 1: source 2 is actually read.
- `ds_dest` in 5: destination register.
- `ds_reg_we` in 1: instruction writes `ds_dest`.
- `ds_is_load` in 1: instruction is a load.
- `ds_is_div` in 1: instruction is a div/mod.
- `es_allowin` in 1: execute can accept this cycle.
- `ms_load_done` in 1: load data returned this cycle and is forwardable from the next cycle on.
- `ms_load_dest` in 5: destination of the returning load.
- `flush` in 1: pipeline flush (exception/ertn); kills all younger in-flight work.
- `ds_stall` out 1: decode must not issue.
- `div_busy` out 1: divider occupied.
- `pending` out 32: scoreboard vector, bit r = register r awaiting a long-latency write.

## Operation
- Issue: `issue = ds_valid & es_allowin & ~ds_stall & ~flush`.
- Tracked write: `trk = ds_reg_we & (ds_dest != 0) & (ds_is_load | ds_is_div)`.
- On issue with trk, `pending[ds_dest]` is set at the next edge.
  - If the instruction is a div, also `div_cnt <= DIV_LAT` and `div_dest <= ds_dest`.
  - A div with `ds_dest == 0` or `~ds_reg_we` still loads `div_cnt`; `div_dest` is then 0.
- Ordinary ALU writes never set pending; forwarding covers them.
- Div countdown:
  - `div_cnt` is 4 bits and decrements each cycle while nonzero.
  - `div_done = (div_cnt == 1)`; on `div_done`, `pending[div_dest]` clears at the next edge.
  - `div_busy = (div_cnt != 0)`.
- Load completion: `ms_load_done` clears `pending[ms_load_dest]` at the next edge. A clear aimed at register 0 is ignored.
- Effective busy mask: `eff = pending` with the bit being cleared this cycle (load or div completion) masked off. A result completing this cycle is forwardable next cycle, when the consumer reaches execute.
- `ds_stall` is asserted (combinational, same cycle) when `ds_valid & ~flush` and any of the following holds:
  - RAW: `ds_src1_used & eff[ds_rf_raddr1]`, or `ds_src2_used & eff[ds_rf_raddr2]`.
  - WAW: `ds_reg_we & eff[ds_dest]`. This guarantees at most one outstanding tracked writer per register.
  - Structural: `ds_is_div & div_busy & ~div_done`.
- Register 0 is never pending; `pending[0]` is constant 0.
- Simultaneous events at the same edge:
  - Set and clear on the same register: set wins. Unreachable under WAW, but required.
  - Div issuing in the cycle the previous div completes: `div_cnt` reloads to `DIV_LAT` and the old `div_dest` bit clears.
  - `flush` overrides everything. The next edge clears all pending bits, `div_cnt` and `div_dest`, and no set occurs.
  - `ms_load_done` for a register that is not pending is harmless.

## Timing
- Reset (async, `resetn` low): `pending = 0`, `div_cnt = 0`, `div_dest = 0`. Outputs read `ds_stall = 0`, `div_busy = 0`, `pending = 0`. Release is synchronous to `clk`.
- `ds_stall` has zero latency, combinational from registered state and current inputs. `pending` and `div_busy` are registered-state outputs.
- Load consumer: if `ms_load_done` is high in cycle N, a dependent in decode has `ds_stall` low in cycle N.
- Div consumer: a div issued in cycle 0 drives `div_done` in cycle `DIV_LAT`. A dependent in decode stalls through cycle `DIV_LAT-1` and is released in cycle `DIV_LAT`.
- Back-to-back divs: the second div can issue in cycle `DIV_LAT`.
- Mid-operation `resetn` assertion clears state immediately, with no clock edge required.

## Test plan
- Reset: `resetn` low, `ds_valid=1`, `ds_src1_used=1`, raddr1=5 -> `ds_stall=0`, `pending=0`, `div_busy=0`.
- Load-use: load r4 issued cycle 0; next op reads r4 -> `ds_stall=1` until the cycle `ms_load_done=1` with dest 4; stall low in that same cycle, `pending[4]` low the cycle after.
- Divider, `DIV_LAT=8`: div r7 issued cycle 0; consumer of r7 -> stall cycles 1..7, low in cycle 8. A second div presented in cycle 3 -> stalls until cycle 8.
- WAW and r0: load to r9 pending, then ALU op writing r9 -> stalled. Load to r0 -> `pending` unchanged, no stall for readers of r0.
- Flush: pending r3 and r12 plus busy divider; `flush=1` for one cycle -> next cycle `pending=0`, `div_busy=0`, a reader of r3 is not stalled. A load issued in the flush cycle sets nothing.
- Simultaneous: div r2 completes (`div_done`) while a new div r6 issues and `ms_load_done` clears r10 -> after the edge `pending[2]=0`, `pending[6]=1`, `pending[10]=0`, `div_cnt=8`.
